// File: rtl/mem_seq_pkg.sv
// Shared constants for the memory cycle sequencer: state codes, transfer direction
// and the default response timeout.
package mem_seq_pkg;

  localparam int unsigned TMO_CYCLES_DEF = 255;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_REQ  = 3'd1;
  localparam state_t ST_XFER = 3'd2;
  localparam state_t ST_REL  = 3'd3;
  localparam state_t ST_FIN  = 3'd4;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_W = 1'b1;

endpackage

// File: rtl/mem_tmo.sv
// Saturating timeout counter with synchronous clear and count enable; flags expiry
// when the count reaches TMO_CYCLES-1.
module mem_tmo #(
  parameter int unsigned TMO_CYCLES = 255,
  parameter int unsigned TMO_W      = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_exp
);

  localparam logic [TMO_W-1:0] CntMax   = '1;
  localparam logic [TMO_W-1:0] CntLimit = TMO_W'(TMO_CYCLES - 1);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CntMax)) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

  assign o_exp = (r_cnt == CntLimit);

endmodule

// File: rtl/mem_seq.sv
// CPU-side memory cycle sequencer: runs one request/grant/ack/release bus handshake
// per start pulse and reports read data, no-answer alarm and parity error.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF,
  parameter int unsigned TMO_W      = 16
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        start_r,
  input  logic        start_w,
  input  logic [0:15] dad,
  input  logic [0:15] ddt,
  input  logic [0:3]  nb,
  output logic        rq,
  input  logic        grant,
  output logic [0:15] mem_ad,
  output logic [0:3]  mem_nb,
  output logic [0:15] mem_dto,
  output logic        mem_w,
  output logic        mem_r,
  input  logic [0:15] mem_dti,
  input  logic        ok,
  input  logic        en,
  input  logic        pe,
  output logic [0:15] rdt,
  output logic        busy,
  output logic        done,
  output logic        alarm,
  output logic        perr
);

  state_t      r_state;
  state_t      w_state_d;
  logic [0:15] r_ad;
  logic [0:15] r_dt;
  logic [0:3]  r_nb;
  logic        r_dir;
  logic [0:15] r_rdt;
  logic        r_alarm;
  logic        r_perr;

  logic w_start;
  logic w_tmo_clr;
  logic w_tmo_en;
  logic w_tmo_exp;
  logic w_xfer;

  assign w_start = start_r | start_w;
  assign w_xfer  = (r_state == ST_XFER);

  // One counter covers both the request-to-response and the release intervals.
  mem_tmo #(
    .TMO_CYCLES(TMO_CYCLES),
    .TMO_W     (TMO_W)
  ) u_tmo (
    .i_clk(clk_sys),
    .i_rst(rst),
    .i_clr(w_tmo_clr),
    .i_en (w_tmo_en),
    .o_exp(w_tmo_exp)
  );

  assign w_tmo_en = (r_state == ST_REQ) || (r_state == ST_XFER) || (r_state == ST_REL);

  always_comb begin
    w_state_d = r_state;
    w_tmo_clr = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) begin
        w_state_d = ST_REQ;
        w_tmo_clr = 1'b1;
      end
      ST_REQ:  if (grant) w_state_d = ST_XFER;
      ST_XFER: if (en || ok || w_tmo_exp) begin
        w_state_d = ST_REL;
        w_tmo_clr = 1'b1;
      end
      ST_REL:  if ((!ok && !en) || w_tmo_exp) w_state_d = ST_FIN;
      ST_FIN:  w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ad    <= '0;
      r_dt    <= '0;
      r_nb    <= '0;
      r_dir   <= DIR_R;
      r_rdt   <= '0;
      r_alarm <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_ad    <= dad;
          r_dt    <= ddt;
          r_nb    <= nb;
          r_dir   <= start_w ? DIR_W : DIR_R;
          r_alarm <= 1'b0;
          r_perr  <= 1'b0;
        end
        ST_XFER: begin
          if (en) begin
            r_alarm <= 1'b1;
          end else if (ok) begin
            if (r_dir == DIR_R) r_rdt <= mem_dti;
            if (pe) r_perr <= 1'b1;
          end else if (w_tmo_exp) begin
            r_alarm <= 1'b1;
          end
        end
        // Responder never released the bus.
        ST_REL: if ((ok || en) && w_tmo_exp) r_alarm <= 1'b1;
        default: ;
      endcase
    end
  end

  assign rq      = (r_state == ST_REQ) || w_xfer;
  assign mem_ad  = r_ad;
  assign mem_nb  = r_nb;
  assign mem_w   = w_xfer && (r_dir == DIR_W);
  assign mem_r   = w_xfer && (r_dir == DIR_R);
  assign mem_dto = (w_xfer && (r_dir == DIR_W)) ? r_dt : '0;
  assign rdt     = r_rdt;
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_FIN);
  assign alarm   = r_alarm;
  assign perr    = r_perr;

endmodule

// File: tb/tb_mem_seq.sv
// Self-checking bench for mem_seq: transaction-level timeline model of each bus cycle,
// directed cases followed by randomized transactions.
module tb_mem_seq;

  localparam int TMO = 8;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        start_r, start_w;
  logic [0:15] dad, ddt;
  logic [0:3]  nb;
  logic        rq, grant;
  logic [0:15] mem_ad;
  logic [0:3]  mem_nb;
  logic [0:15] mem_dto;
  logic        mem_w, mem_r;
  logic [0:15] mem_dti;
  logic        ok, en, pe;
  logic [0:15] rdt;
  logic        busy, done, alarm, perr;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] m_rdt;

  always #5 clk_sys = ~clk_sys;

  mem_seq #(
    .TMO_CYCLES(TMO),
    .TMO_W     (16)
  ) dut (
    .clk_sys(clk_sys),
    .rst    (rst),
    .start_r(start_r),
    .start_w(start_w),
    .dad    (dad),
    .ddt    (ddt),
    .nb     (nb),
    .rq     (rq),
    .grant  (grant),
    .mem_ad (mem_ad),
    .mem_nb (mem_nb),
    .mem_dto(mem_dto),
    .mem_w  (mem_w),
    .mem_r  (mem_r),
    .mem_dti(mem_dti),
    .ok     (ok),
    .en     (en),
    .pe     (pe),
    .rdt    (rdt),
    .busy   (busy),
    .done   (done),
    .alarm  (alarm),
    .perr   (perr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = ok answer, 1 = en (no module), 2 = no answer.
  // gd: REQ cycles before grant; dly: XFER cycles before answer; rel: REL cycles answer stays high.
  task automatic run_seq(input bit is_w, input logic [15:0] a, input logic [15:0] dw,
                         input logic [15:0] rdv, input logic [3:0] b, input int gd,
                         input int kind, input int dly, input int rel, input bit pei);
    int          xs, xl, rs, rl, fs, to_idx;
    bit          resp, in_req, in_x, in_rel, sig, e_alarm, e_perr;
    logic [15:0] e_rdt;
    xs     = gd + 1;
    to_idx = TMO - 2 - gd;  // XFER cycle index where timeout fires; negative means never
    resp   = (kind != 2) && ((to_idx < 0) || (dly <= to_idx));
    xl     = resp ? dly + 1 : to_idx + 1;
    rs     = xs + xl;
    rl     = resp ? (((rel < TMO) ? rel : TMO - 1) + 1) : 1;
    fs     = rs + rl;
    e_alarm = !resp || (kind == 1) || (rel >= TMO);
    e_perr  = resp && (kind == 0) && pei;
    e_rdt   = (resp && (kind == 0) && !is_w) ? rdv : m_rdt;

    @(negedge clk_sys);
    chk("idle_busy", 32'(busy), 0);
    start_w = is_w;
    start_r = is_w ? 1'($urandom_range(0, 1)) : 1'b1;
    dad = a; ddt = dw; nb = b;
    grant = 1'b0; ok = 1'b0; en = 1'b0; pe = 1'b0;
    for (int t = 0; t <= fs + 1; t++) begin
      @(negedge clk_sys);
      in_req = (t < xs);
      in_x   = (t >= xs) && (t < rs);
      in_rel = (t >= rs) && (t < fs);
      if (t <= fs) begin
        chk("busy", 32'(busy), 1);
        chk("rq", 32'(rq), 32'(in_req || in_x));
        chk("mem_r", 32'(mem_r), 32'(in_x && !is_w));
        chk("mem_w", 32'(mem_w), 32'(in_x && is_w));
        chk("mem_dto", 32'(mem_dto), (in_x && is_w) ? 32'(dw) : 0);
        chk("done", 32'(done), 32'(t == fs));
        if (in_x) begin
          chk("mem_ad", 32'(mem_ad), 32'(a));
          chk("mem_nb", 32'(mem_nb), 32'(b));
        end
        if (t == 0) begin
          chk("alarm_clr", 32'(alarm), 0);
          chk("perr_clr", 32'(perr), 0);
        end
      end else begin
        chk("end_busy", 32'(busy), 0);
        chk("end_done", 32'(done), 0);
        chk("alarm", 32'(alarm), 32'(e_alarm));
        chk("perr", 32'(perr), 32'(e_perr));
        chk("rdt", 32'(rdt), 32'(e_rdt));
      end
      // Drive the next cycle's inputs; starts while busy must be ignored.
      start_r = (t < fs + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      start_w = (t < fs + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      dad = 16'($urandom); ddt = 16'($urandom); nb = 4'($urandom);
      if (in_req)               grant = (t == gd);
      else if (in_x || in_rel)  grant = 1'($urandom_range(0, 1));
      else                      grant = 1'b0;
      if (in_x)        sig = (kind != 2) && ((t - xs) >= dly);
      else if (in_rel) sig = resp && ((t - rs) < rel);
      else             sig = 1'b0;
      ok      = sig && (kind == 0);
      en      = sig && (kind == 1);
      pe      = (in_x || in_rel) ? pei : 1'b0;
      mem_dti = in_x ? rdv : 16'($urandom);
    end
    m_rdt = e_rdt;
  endtask

  initial begin
    rst = 1'b1; start_r = 1'b0; start_w = 1'b0; dad = '0; ddt = '0; nb = '0;
    grant = 1'b0; mem_dti = '0; ok = 1'b0; en = 1'b0; pe = 1'b0;
    m_rdt = 16'h0000;
    repeat (2) @(negedge clk_sys);
    chk("rst_rq", 32'(rq), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_perr", 32'(perr), 0);
    chk("rst_rdt", 32'(rdt), 0);
    chk("rst_mem_ad", 32'(mem_ad), 0);
    chk("rst_strobes", 32'({mem_r, mem_w}), 0);
    rst = 1'b0;

    // Directed cases
    run_seq(1'b0, 16'h1234, 16'h0000, 16'hBEEF, 4'h3, 0, 0, 2, 1, 1'b0);  // read
    run_seq(1'b1, 16'h0F0F, 16'hA5A5, 16'h7777, 4'h9, 10, 0, 0, 1, 1'b0); // late grant write
    run_seq(1'b0, 16'h2222, 16'h0000, 16'h5555, 4'h1, 0, 1, 1, 2, 1'b0);  // no module
    run_seq(1'b0, 16'h3333, 16'h0000, 16'h6666, 4'h2, 0, 2, 0, 0, 1'b0);  // response timeout
    run_seq(1'b0, 16'h4444, 16'h0000, 16'h0001, 4'h4, 1, 0, 0, 0, 1'b1);  // parity error
    run_seq(1'b0, 16'h4445, 16'h0000, 16'h1357, 4'h4, 0, 0, 0, 0, 1'b0);  // clean read clears perr
    run_seq(1'b1, 16'h5555, 16'h1111, 16'h0000, 4'h5, 2, 0, 1, 10, 1'b0); // release timeout

    // Reset in the middle of XFER
    @(negedge clk_sys);
    start_r = 1'b1; dad = 16'h6789; nb = 4'h6;
    @(negedge clk_sys);
    start_r = 1'b0; grant = 1'b1;
    @(negedge clk_sys);
    chk("mid_mem_r", 32'(mem_r), 1);
    grant = 1'b0; rst = 1'b1;
    @(negedge clk_sys);
    chk("mid_rst_rq", 32'(rq), 0);
    chk("mid_rst_mem_r", 32'(mem_r), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_rdt", 32'(rdt), 0);
    rst = 1'b0;
    m_rdt = 16'h0000;
    run_seq(1'b0, 16'h0ABC, 16'h0000, 16'hCAFE, 4'hA, 0, 0, 0, 0, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 24; i++) begin
      run_seq(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom),
              4'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 9)),
              1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
